// File: rtl/ddr_wr_burst_ctrl.sv
// ddr_wr_burst_ctrl
//   Write-side burst scheduler. It sits between the read port of the write
//   FIFO and the AXI write channels of the DDR controller. When enough beats
//   are buffered it issues one AXI INCR burst and drains the FIFO under
//   wready backpressure. It walks a linear frame buffer, given as a base
//   address and a frame length in beats, and wraps to the base at frame end.
//   The whole block runs in the FIFO read-clock (DDR user) domain.
//
//   Optional feature: WR_BURST_TIMEOUT_EN. When this macro is defined, a
//   partial burst is flushed after TIMEOUT_CYC idle cycles.
//
// Ports
//   clk, rst              single clock; asynchronous active-high reset
//   enable                allow new bursts (looked at only while idle)
//   cfg_base_addr         frame base byte address, beat aligned
//   cfg_frame_beats       frame length in beats (0 = never start)
//   fifo_rd_*             prefetch FIFO read port (head data valid while !empty)
//   aw*, w*, b*           AXI write address / data / response channels
//   busy                  high in any state other than IDLE
//   frame_done            one-cycle pulse when the last burst of a frame is acked
//   dbg_state             current FSM state, for observation
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. Once valid is raised it stays high, with stable payload, until that
// transfer cycle.
module ddr_wr_burst_ctrl #(
  parameter int DATA_WIDTH  = 256,
  parameter int LEVEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WIDTH = 20
`ifdef WR_BURST_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [FRAME_WIDTH-1:0] cfg_frame_beats,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [7:0]             awlen,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wvalid,
  output logic                   wlast,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  localparam int LEN_W = 9;              // holds burst lengths 1..256
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   frame_active_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [FRAME_WIDTH-1:0] beats_left_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       beat_cnt_q;
  logic                   awvalid_q;
  logic [ADDR_WIDTH-1:0]  awaddr_q;
  logic [7:0]             awlen_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic                   busy_q;
  logic                   frame_done_q;

  // Launch decision, evaluated every cycle and used only in IDLE.
  logic [LEN_W-1:0] full_len;
  logic [LEN_W-1:0] launch_len;
  logic             launch_full;
  logic             launch_go;

`ifdef WR_BURST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            partial;
`endif

  always_comb begin
    // A burst is BURST_LEN beats, or whatever is left at the frame tail.
    if (beats_left_q >= FRAME_WIDTH'(BURST_LEN)) begin
      full_len = LEN_W'(BURST_LEN);
    end else begin
      full_len = LEN_W'(beats_left_q);
    end
    launch_full = (32'(fifo_rd_water_level) >= 32'(full_len));
    launch_go   = launch_full;
    launch_len  = full_len;
`ifdef WR_BURST_TIMEOUT_EN
    partial = (fifo_rd_water_level != '0) && !launch_full;
    if (partial && (to_cnt_q == TO_W'(TIMEOUT_CYC))) begin
      // Flush whatever is buffered as a short burst.
      launch_go  = 1'b1;
      launch_len = LEN_W'(fifo_rd_water_level);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      frame_active_q <= 1'b0;
      addr_q         <= '0;
      beats_left_q   <= '0;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      awvalid_q      <= 1'b0;
      awaddr_q       <= '0;
      awlen_q        <= '0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
`ifdef WR_BURST_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
`ifdef WR_BURST_TIMEOUT_EN
      // The counter clears on every cycle where it does not count, so a
      // launch clears it as well.
      if ((state_q == S_IDLE) && frame_active_q && enable && partial && !launch_go) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
        to_cnt_q <= '0;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            if (!frame_active_q) begin
              // Frame load takes a cycle of its own and issues no burst.
              if (cfg_frame_beats != '0) begin
                addr_q         <= cfg_base_addr;
                beats_left_q   <= cfg_frame_beats;
                frame_active_q <= 1'b1;
              end
            end else if (launch_go) begin
              len_q     <= launch_len;
              awaddr_q  <= addr_q;
              awlen_q   <= 8'(launch_len - 1'b1);
              awvalid_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (wready) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == (len_q - 1'b1)) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bvalid) begin
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= addr_q + (ADDR_WIDTH'(len_q) * ADDR_WIDTH'(BYTES));
            beats_left_q <= beats_left_q - FRAME_WIDTH'(len_q);
            if (beats_left_q == FRAME_WIDTH'(len_q)) begin
              // Clearing frame_active makes the next frame reload the config.
              frame_done_q   <= 1'b1;
              frame_active_q <= 1'b0;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data passes straight from the FIFO head. The empty term is defensive
  // only: launch guarantees len beats are buffered before DATA is entered.
  assign fifo_rd_en = wvalid_q & wready & ~fifo_rd_empty;
  assign wdata      = wvalid_q ? fifo_rd_data : '0;
  assign wlast      = wvalid_q & (beat_cnt_q == (len_q - 1'b1));
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign awlen      = awlen_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Testbench for ddr_wr_burst_ctrl: a table of burst records (config, W-channel
// pacing, expected AW fields, expected frame_done), plus hand-written
// sequences for enable drop, reset mid-burst and the partial-burst level hold.
// The FIFO model pushes each beat to a scoreboard queue. The queue is popped
// on every W handshake.
module tb_ddr_wr_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [27:0]  cfg_base_addr = '0;
  logic [19:0]  cfg_frame_beats = '0;
  logic         fifo_rd_en;
  logic [255:0] fifo_rd_data;
  logic         fifo_rd_empty;
  logic [7:0]   fifo_rd_water_level;
  logic [27:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [255:0] wdata;
  logic         wvalid;
  logic         wlast;
  logic         wready = 1'b0;
  logic         bvalid = 1'b0;
  logic         bready;
  logic         busy;
  logic         frame_done;
  logic [1:0]   dbg_state;

  ddr_wr_burst_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .cfg_base_addr       (cfg_base_addr),
    .cfg_frame_beats     (cfg_frame_beats),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .awaddr              (awaddr),
    .awlen               (awlen),
    .awvalid             (awvalid),
    .awready             (awready),
    .wdata               (wdata),
    .wvalid              (wvalid),
    .wlast               (wlast),
    .wready              (wready),
    .bvalid              (bvalid),
    .bready              (bready),
    .busy                (busy),
    .frame_done          (frame_done),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model and scoreboard ----------------
  logic [255:0] fq[$];     // FIFO contents as seen by the DUT
  logic [255:0] exp_q[$];  // beats expected on the W channel, in order
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_rd_data        = (fq.size() > 0) ? fq[0] : '0;
    fifo_rd_empty       = (fq.size() == 0);
    fifo_rd_water_level = 8'(fq.size());
  endtask

  task automatic top_up(input int n);
    logic [255:0] d;
    while (fq.size() < n) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      fq.push_back(d);
      exp_q.push_back(d);
    end
    refresh();
  endtask

  // Advance one cycle. Callers settle inputs (#1) before calling, so the
  // pop decision sampled here is the one the DUT sees at the next posedge.
  task automatic step();
    logic p;
    p = fifo_rd_en;
    @(negedge clk);
    if (p) begin
      if (fq.size() == 0) chk("fifo_underflow", 1, 0);
      else void'(fq.pop_front());
    end
    refresh();
  endtask

  // ---------------- driver: one complete burst ----------------
  task automatic do_burst(input logic [27:0] base, input logic [19:0] frame, input int wmode,
                          input logic [27:0] ea, input logic [7:0] el, input logic ed,
                          input int fill, input int drop_beat, input int rst_beat);
    logic found, hs, tog, done, seen;
    int beat, nd;
    cfg_base_addr   = base;
    cfg_frame_beats = frame;
    enable          = 1'b1;
    top_up(fill);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(); #1;
      if (awvalid) found = 1'b1;
    end
    chk("aw_seen", found, 1);
    if (!found) return;
    chk("awaddr", awaddr, ea);
    chk("awlen", awlen, el);
    chk("aw_w_exclusive", wvalid, 0);
    chk("busy_in_addr", busy, 1);
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      awready = (i >= 3) || ($urandom_range(0, 1) == 1);
      #1;
      hs = awready && awvalid;
      step();
    end
    awready = 1'b0;
    chk("aw_handshake", hs, 1);
    beat = 0; tog = 1'b1; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      case (wmode)
        0:       wready = 1'b1;
        1:       begin wready = tog; tog = ~tog; end
        default: wready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (i == 0) chk("w_latency", wvalid, 1);
      if (rst_beat >= 0 && beat == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_ctrl_outs", {awvalid, wvalid, wlast, bready, busy, frame_done, fifo_rd_en}, 0);
        chk("rst_aw_fields", {awaddr, awlen}, 0);
        chk("rst_state", dbg_state, 0);
        step();
        fq.delete(); exp_q.delete(); refresh();
        wready = 1'b0;
        rst = 1'b0;
        return;
      end
      if (drop_beat >= 0 && beat == drop_beat) enable = 1'b0;
      if (wvalid && wready) begin
        chk("rd_en_on_hs", fifo_rd_en, 1);
        chk("wlast", wlast, (beat == int'(el)));
        if (exp_q.size() > 0) chk("wdata", wdata, exp_q.pop_front());
        else chk("wdata_unexpected_beat", 1, 0);
        beat++;
        done = (beat == int'(el) + 1);
      end else begin
        chk("rd_en_on_stall", fifo_rd_en, 0);
        if (wvalid && exp_q.size() > 0) chk("wdata_stall", wdata, exp_q[0]);
      end
      step();
    end
    wready = 1'b0;
    chk("beat_count", beat, int'(el) + 1);
    if (!done) return;
    #1;
    chk("bready_latency", bready, 1);
    chk("wvalid_after_last", wvalid, 0);
    nd = $urandom_range(0, 3);
    for (int i = 0; i < nd; i++) begin
      step(); #1;
      chk("bready_hold", bready, 1);
    end
    bvalid = 1'b1;
    #1;
    step();
    bvalid = 1'b0;
    #1;
    chk("frame_done", frame_done, ed);
    chk("busy_after_b", busy, 0);
    if (drop_beat >= 0) begin
      top_up(32);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        step(); #1;
        if (awvalid) seen = 1'b1;
      end
      chk("no_aw_while_disabled", seen, 0);
      chk("idle_while_disabled", busy, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [27:0] base;
    logic [19:0] frame;
    int          wmode;    // 0: wready=1, 1: toggle 1/0, 2: random
    logic [27:0] exp_addr;
    logic [7:0]  exp_len;
    logic        exp_done;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic seen;
    int cyc;
    vt[0] = '{28'h1000, 20'd64, 0, 28'h1000, 8'd15, 1'b0};
    vt[1] = '{28'h1000, 20'd64, 0, 28'h1200, 8'd15, 1'b0};
    vt[2] = '{28'h1000, 20'd64, 1, 28'h1400, 8'd15, 1'b0};
    vt[3] = '{28'h1000, 20'd64, 2, 28'h1600, 8'd15, 1'b1};
    vt[4] = '{28'h1000, 20'd40, 0, 28'h1000, 8'd15, 1'b0};
    vt[5] = '{28'h1000, 20'd40, 2, 28'h1200, 8'd15, 1'b0};
    vt[6] = '{28'h1000, 20'd40, 0, 28'h1400, 8'd7,  1'b1};
    vt[7] = '{28'h1000, 20'd40, 0, 28'h1000, 8'd15, 1'b0};

    refresh();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl_outs", {awvalid, wvalid, wlast, bready, busy, frame_done, fifo_rd_en}, 0);
    chk("reset_aw_fields", {awaddr, awlen}, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_burst(vt[v].base, vt[v].frame, vt[v].wmode, vt[v].exp_addr, vt[v].exp_len,
               vt[v].exp_done, 16, -1, -1);
    end

    // enable dropped at beat 3: burst completes, then no further bursts
    do_burst(28'h1000, 20'd40, 0, 28'h1200, 8'd15, 1'b0, 16, 3, -1);

    // reset at beat 5 of the 8-beat frame tail, then restart at base
    do_burst(28'h1000, 20'd40, 0, 28'h1400, 8'd7, 1'b0, 16, -1, 5);
    do_burst(28'h1000, 20'd64, 0, 28'h1000, 8'd15, 1'b0, 16, -1, -1);

    // level held at 5 with 48 beats left in the frame
    top_up(5);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step(); #1;
      cyc++;
      if (awvalid) seen = 1'b1;
    end
`ifdef WR_BURST_TIMEOUT_EN
    chk("flush_seen", seen, 1);
    chk("flush_delay_in_range", (cyc >= 250 && cyc <= 270), 1);
    if (seen) do_burst(28'h1000, 20'd64, 0, 28'h1200, 8'd4, 1'b0, 5, -1, -1);
`else
    chk("no_partial_burst", seen, 0);
    chk("idle_at_level5", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
